// File: rtl/pipe_hazard_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module      : pipe_hazard_ctrl                                           |
// | Description : Stall/flush sequencer for a 5-stage IF/ID/EX/MEM/WB        |
// |               pipeline. Arbitrates data-memory wait, multicycle multiply,|
// |               EX redirect and load-use hazards into per-register hold    |
// |               and bubble controls. Outputs are combinational.            |
// | Option      : PIPE_CTRL_PERF_EN enables saturating perf counters.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int FLUSH_SLOTS = 1,
  parameter int PERF_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_hazard,
  input  logic              ex_mul_start,
  input  logic              ex_redirect,
  input  logic              dmem_busy,
  input  logic              perf_clr,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_ex_stall,
  output logic              ex_mem_stall,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              ex_mem_bubble,
  output logic              mem_wb_bubble,
  output logic              mul_busy,
  output logic [1:0]        ctrl_state,
  output logic [PERF_W-1:0] perf_stall_cycles,
  output logic [PERF_W-1:0] perf_flush_cycles
);

  // Shared down-counter must hold the larger of the two sequence lengths.
  localparam int c_CNT_MAX = (MUL_LATENCY > FLUSH_SLOTS) ? MUL_LATENCY : FLUSH_SLOTS;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;

  localparam bit c_MUL_STALLS  = (MUL_LATENCY > 1);
  localparam bit c_FLUSH_MULTI = (FLUSH_SLOTS > 1);

  localparam logic [c_CNT_W-1:0] c_MUL_LOAD   = c_CNT_W'((MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0);
  localparam logic [c_CNT_W-1:0] c_FLUSH_LOAD = c_CNT_W'((FLUSH_SLOTS > 1) ? (FLUSH_SLOTS - 2) : 0);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MUL   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;

  logic w_pc_stall;
  logic w_if_id_stall;
  logic w_id_ex_stall;
  logic w_ex_mem_stall;
  logic w_if_id_flush;
  logic w_id_ex_bubble;
  logic w_ex_mem_bubble;
  logic w_mem_wb_bubble;
  logic w_mul_busy;

  // State and sequence counter register; reset abandons any sequence.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and control decode, priority dmem_busy > multiply > redirect > load-use.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_pc_stall      = 1'b0;
    w_if_id_stall   = 1'b0;
    w_id_ex_stall   = 1'b0;
    w_ex_mem_stall  = 1'b0;
    w_if_id_flush   = 1'b0;
    w_id_ex_bubble  = 1'b0;
    w_ex_mem_bubble = 1'b0;
    w_mem_wb_bubble = 1'b0;
    w_mul_busy      = 1'b0;

    if (dmem_busy) begin
      // Freeze everything upstream of MEM; the sequence counter still runs
      // down (stopping at zero) but no state transition is taken.
      w_pc_stall      = 1'b1;
      w_if_id_stall   = 1'b1;
      w_id_ex_stall   = 1'b1;
      w_ex_mem_stall  = 1'b1;
      w_mem_wb_bubble = 1'b1;
      w_mul_busy      = (r_state == ST_MUL);
      if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - c_CNT_ONE;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (ex_mul_start && c_MUL_STALLS) begin
            w_pc_stall      = 1'b1;
            w_if_id_stall   = 1'b1;
            w_id_ex_stall   = 1'b1;
            w_ex_mem_bubble = 1'b1;
            w_mul_busy      = 1'b1;
            w_cnt_nxt       = c_MUL_LOAD;
            w_state_nxt     = ST_MUL;
          end else if (ex_redirect) begin
            // Instruction in ID is wrong-path, so its load-use hazard is moot.
            w_if_id_flush = 1'b1;
            if (c_FLUSH_MULTI) begin
              w_cnt_nxt   = c_FLUSH_LOAD;
              w_state_nxt = ST_FLUSH;
            end
          end else if (ld_hazard) begin
            w_pc_stall     = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_ex_bubble = 1'b1;
          end
        end

        ST_MUL: begin
          w_mul_busy = 1'b1;
          if (r_cnt != '0) begin
            w_pc_stall      = 1'b1;
            w_if_id_stall   = 1'b1;
            w_id_ex_stall   = 1'b1;
            w_ex_mem_bubble = 1'b1;
            w_cnt_nxt       = r_cnt - c_CNT_ONE;
          end else begin
            // Release cycle: a redirect from the multiply's instruction slot
            // is honoured here.
            w_state_nxt = ST_RUN;
            if (ex_redirect) begin
              w_if_id_flush = 1'b1;
              if (c_FLUSH_MULTI) begin
                w_cnt_nxt   = c_FLUSH_LOAD;
                w_state_nxt = ST_FLUSH;
              end
            end
          end
        end

        ST_FLUSH: begin
          w_if_id_flush = 1'b1;
          if (r_cnt == '0) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_cnt_nxt = r_cnt - c_CNT_ONE;
          end
        end

        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // All controls are held low while reset is asserted.
  assign pc_stall      = ~reset & w_pc_stall;
  assign if_id_stall   = ~reset & w_if_id_stall;
  assign id_ex_stall   = ~reset & w_id_ex_stall;
  assign ex_mem_stall  = ~reset & w_ex_mem_stall;
  assign if_id_flush   = ~reset & w_if_id_flush;
  assign id_ex_bubble  = ~reset & w_id_ex_bubble;
  assign ex_mem_bubble = ~reset & w_ex_mem_bubble;
  assign mem_wb_bubble = ~reset & w_mem_wb_bubble;
  assign mul_busy      = ~reset & w_mul_busy;
  assign ctrl_state    = reset ? 2'd0 : r_state;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] r_perf_stall;
  logic [PERF_W-1:0] r_perf_flush;

  // Saturating count of PC-hold cycles; clear beats increment.
  always_ff @(posedge clock) begin
    if (reset || perf_clr) begin
      r_perf_stall <= '0;
    end else if (w_pc_stall && (r_perf_stall != '1)) begin
      r_perf_stall <= r_perf_stall + PERF_W'(1);
    end
  end

  // Saturating count of IF/ID flush cycles; clear beats increment.
  always_ff @(posedge clock) begin
    if (reset || perf_clr) begin
      r_perf_flush <= '0;
    end else if (w_if_id_flush && (r_perf_flush != '1)) begin
      r_perf_flush <= r_perf_flush + PERF_W'(1);
    end
  end

  assign perf_stall_cycles = reset ? '0 : r_perf_stall;
  assign perf_flush_cycles = reset ? '0 : r_perf_flush;
`else
  logic w_unused_perf_clr;
  assign w_unused_perf_clr = perf_clr;
  assign perf_stall_cycles = '0;
  assign perf_flush_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_pipe_hazard_ctrl                                        |
// | Description : Scoreboard bench for pipe_hazard_ctrl. Directed vectors    |
// |               push hand-computed expectations; a negedge monitor pops    |
// |               and compares each cycle. Define PIPE_CTRL_PERF_EN to add   |
// |               the perf-counter saturation/clear vectors.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam int c_PERF_W = 4;

  // Expected control fields, bit order:
  // [8]pc_stall [7]if_id_stall [6]id_ex_stall [5]ex_mem_stall [4]if_id_flush
  // [3]id_ex_bubble [2]ex_mem_bubble [1]mem_wb_bubble [0]mul_busy
  localparam logic [8:0] c_NONE = 9'b000000000;
  localparam logic [8:0] c_LD   = 9'b110001000;
  localparam logic [8:0] c_MULS = 9'b111000101;
  localparam logic [8:0] c_REL  = 9'b000000001;
  localparam logic [8:0] c_FL   = 9'b000010000;
  localparam logic [8:0] c_RELF = 9'b000010001;
  localparam logic [8:0] c_DM   = 9'b111100010;
  localparam logic [8:0] c_DMM  = 9'b111100011;

  typedef struct {
    logic [10:0]         ctl;
    bit                  chk_perf;
    logic [c_PERF_W-1:0] ps;
    logic [c_PERF_W-1:0] pf;
  } exp_t;

  logic clock = 1'b1;
  logic reset, ld_hazard, ex_mul_start, ex_redirect, dmem_busy, perf_clr;
  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush;
  logic id_ex_bubble, ex_mem_bubble, mem_wb_bubble, mul_busy;
  logic [1:0] ctrl_state;
  logic [c_PERF_W-1:0] perf_stall_cycles, perf_flush_cycles;

  exp_t  q[$];
  string nq[$];
  int    passed = 0;
  int    total  = 0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(
    .MUL_LATENCY(4),
    .FLUSH_SLOTS(2),
    .PERF_W     (c_PERF_W)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .ld_hazard        (ld_hazard),
    .ex_mul_start     (ex_mul_start),
    .ex_redirect      (ex_redirect),
    .dmem_busy        (dmem_busy),
    .perf_clr         (perf_clr),
    .pc_stall         (pc_stall),
    .if_id_stall      (if_id_stall),
    .id_ex_stall      (id_ex_stall),
    .ex_mem_stall     (ex_mem_stall),
    .if_id_flush      (if_id_flush),
    .id_ex_bubble     (id_ex_bubble),
    .ex_mem_bubble    (ex_mem_bubble),
    .mem_wb_bubble    (mem_wb_bubble),
    .mul_busy         (mul_busy),
    .ctrl_state       (ctrl_state),
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_cycles(perf_flush_cycles)
  );

  logic [10:0] act;
  assign act = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
                id_ex_bubble, ex_mem_bubble, mem_wb_bubble, mul_busy, ctrl_state};

  // Drive one cycle of inputs {reset,ld,mul,redirect,dmem,perf_clr} and queue
  // the expected control response; perf counters expected idle at zero
  // unless the perf option is built in.
  task automatic step(input logic [5:0] in, input logic [8:0] f,
                      input logic [1:0] st, input string nm);
    exp_t e;
    {reset, ld_hazard, ex_mul_start, ex_redirect, dmem_busy, perf_clr} = in;
    e.ctl = {f, st};
`ifdef PIPE_CTRL_PERF_EN
    e.chk_perf = 1'b0;
`else
    e.chk_perf = 1'b1;
`endif
    e.ps = '0;
    e.pf = '0;
    q.push_back(e);
    nq.push_back(nm);
    @(posedge clock);
    #1;
  endtask

  // Same as step, with explicit perf counter expectations.
  task automatic step_perf(input logic [5:0] in, input logic [8:0] f,
                           input logic [1:0] st, input logic [c_PERF_W-1:0] ps,
                           input logic [c_PERF_W-1:0] pf, input string nm);
    exp_t e;
    {reset, ld_hazard, ex_mul_start, ex_redirect, dmem_busy, perf_clr} = in;
    e.ctl      = {f, st};
    e.chk_perf = 1'b1;
    e.ps       = ps;
    e.pf       = pf;
    q.push_back(e);
    nq.push_back(nm);
    @(posedge clock);
    #1;
  endtask

  // Monitor: compare combinational outputs mid-cycle against the queue head.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        n = nq.pop_front();
        total++;
        if (act !== e.ctl) begin
          $display("FAIL %s: ctl got %b required %b", n, act, e.ctl);
        end else begin
          passed++;
        end
        if (e.chk_perf) begin
          total++;
          if ({perf_stall_cycles, perf_flush_cycles} !== {e.ps, e.pf}) begin
            $display("FAIL %s_perf: stall/flush got %0d/%0d required %0d/%0d",
                     n, perf_stall_cycles, perf_flush_cycles, e.ps, e.pf);
          end else begin
            passed++;
          end
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    step(6'b111111, c_NONE, 2'd0, "reset_all_ones");
    step(6'b111111, c_NONE, 2'd0, "reset_all_ones2");
    step(6'b000000, c_NONE, 2'd0, "post_reset");

    step(6'b010000, c_LD,   2'd0, "ld_hazard");
    step(6'b000000, c_NONE, 2'd0, "ld_done");

    step(6'b001000, c_MULS, 2'd0, "mul_c0");
    step(6'b001000, c_MULS, 2'd1, "mul_c1");
    step(6'b001000, c_MULS, 2'd1, "mul_c2");
    step(6'b001000, c_REL,  2'd1, "mul_release");
    step(6'b000000, c_NONE, 2'd0, "mul_done");

    step(6'b010100, c_FL,   2'd0, "redir_ld_c0");
    step(6'b010000, c_FL,   2'd2, "redir_ld_c1");
    step(6'b000000, c_NONE, 2'd0, "redir_done");

    step(6'b001000, c_MULS, 2'd0, "dm_mul_c0");
    step(6'b001000, c_MULS, 2'd1, "dm_mul_c1");
    step(6'b001010, c_DMM,  2'd1, "dm_busy1");
    step(6'b001010, c_DMM,  2'd1, "dm_busy2");
    step(6'b001010, c_DMM,  2'd1, "dm_busy3");
    step(6'b001000, c_REL,  2'd1, "dm_release");
    step(6'b000000, c_NONE, 2'd0, "dm_done");

    step(6'b010110, c_DM,   2'd0, "prio_dmem");
    step(6'b000000, c_NONE, 2'd0, "prio_done");

    step(6'b001000, c_MULS, 2'd0, "mulr_c0");
    step(6'b001000, c_MULS, 2'd1, "mulr_c1");
    step(6'b001000, c_MULS, 2'd1, "mulr_c2");
    step(6'b001100, c_RELF, 2'd1, "mulr_release_redir");
    step(6'b000000, c_FL,   2'd2, "mulr_flush");
    step(6'b000000, c_NONE, 2'd0, "mulr_done");

    step(6'b001000, c_MULS, 2'd0, "rst_mid_c0");
    step(6'b101000, c_NONE, 2'd0, "rst_mid_reset");
    step(6'b000000, c_NONE, 2'd0, "rst_mid_run");

`ifdef PIPE_CTRL_PERF_EN
    step(6'b000001, c_NONE, 2'd0, "perf_clear");
    for (int k = 0; k < 20; k++) begin
      step_perf(6'b010000, c_LD, 2'd0, c_PERF_W'((k > 15) ? 15 : k), '0, "perf_sat");
    end
    step_perf(6'b000001, c_NONE, 2'd0, 4'd15, 4'd0, "perf_clr_cycle");
    step_perf(6'b000000, c_NONE, 2'd0, 4'd0,  4'd0, "perf_cleared");
`endif

    step(6'b000000, c_NONE, 2'd0, "idle_end");

    begin : drain
      for (int i = 0; i < 10; i++) begin
        if (q.size() == 0) break;
        @(posedge clock);
      end
    end
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
